// File: rtl/bec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bec_pkg
// Description : Shared widths and FSM state encoding for the BEC result path.
// Revision    : 1.0 - initial release
// ============================================================================
package bec_pkg;

    localparam int BEC_DATA_W    = 163;
    localparam int BEC_WORD_W    = 32;
    localparam int BEC_NUM_WORDS = (BEC_DATA_W + BEC_WORD_W - 1) / BEC_WORD_W;
    localparam int BEC_STATUS_W  = 4;
    localparam int BEC_IDX_W     = 3;

    typedef enum logic [1:0] {
        BEC_IDLE   = 2'd0,
        BEC_ARMED  = 2'd1,
        BEC_UNLOAD = 2'd2
    } bec_state_t;

endpackage : bec_pkg
`default_nettype wire

// File: rtl/bec_word_mux.sv
`default_nettype none
// ============================================================================
// Module      : bec_word_mux
// Description : Combinational wide-bus to word slice selector; the last word
//               is zero-padded above the top of the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module bec_word_mux #(
    parameter int DATA_W = 163,
    parameter int WORD_W = 32,
    parameter int IDX_W  = 3
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [WORD_W-1:0] o_word
);

    localparam int NUM_WORDS = (DATA_W + WORD_W - 1) / WORD_W;
    localparam int c_PAD_W   = NUM_WORDS * WORD_W - DATA_W;

    logic [NUM_WORDS*WORD_W-1:0] w_padded;

    generate
        if (c_PAD_W > 0) begin : g_pad
            assign w_padded = {{c_PAD_W{1'b0}}, i_data};
        end else begin : g_nopad
            assign w_padded = i_data;
        end
    endgenerate

    // Indices past the last word select zero.
    always_comb begin
        o_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (i_idx == IDX_W'(k)) begin
                o_word = w_padded[k*WORD_W +: WORD_W];
            end
        end
    end

endmodule : bec_word_mux
`default_nettype wire

// File: rtl/bec_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : bec_result_reader
// Description : Captures the BEC core result on a done rising edge after an
//               arm request and replays it as 32-bit words on a pop handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bec_result_reader
    import bec_pkg::*;
#(
    parameter int DATA_W = BEC_DATA_W,
    parameter int WORD_W = BEC_WORD_W
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    input  logic                    arm,
    input  logic                    slv_done,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [BEC_STATUS_W-1:0] bec_status,
    input  logic                    rd_pop,
    output logic [WORD_W-1:0]       word_out,
    output logic [BEC_IDX_W-1:0]    word_idx,
    output logic                    word_valid,
    output logic                    last_word,
    output logic                    busy,
    output logic [BEC_STATUS_W-1:0] status_out,
    output logic                    overrun
);

    localparam int NUM_WORDS = (DATA_W + WORD_W - 1) / WORD_W;
    localparam logic [BEC_IDX_W-1:0] c_LAST_IDX = BEC_IDX_W'(NUM_WORDS - 1);

    bec_state_t              r_state;
    logic [DATA_W-1:0]       r_capture;
    logic [BEC_IDX_W-1:0]    r_idx;
    logic                    r_valid;
    logic [BEC_STATUS_W-1:0] r_status;
    logic                    r_overrun;
    logic                    r_done_q;

    logic                    w_rise;
    logic [WORD_W-1:0]       w_word;

    assign w_rise = slv_done & ~r_done_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state   <= BEC_IDLE;
            r_capture <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_status  <= '0;
            r_overrun <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_done_q <= slv_done;
            case (r_state)
                BEC_IDLE: begin
                    // A rise coinciding with arm is consumed here, not captured.
                    if (arm) begin
                        r_state   <= BEC_ARMED;
                        r_overrun <= 1'b0;
                    end
                end
                BEC_ARMED: begin
                    if (w_rise) begin
                        r_capture <= data_in;
                        r_status  <= bec_status;
                        r_idx     <= '0;
                        r_valid   <= 1'b1;
                        r_state   <= BEC_UNLOAD;
                    end
                end
                BEC_UNLOAD: begin
                    if (arm) begin
                        r_state   <= BEC_ARMED;
                        r_valid   <= 1'b0;
                        r_idx     <= '0;
                        r_overrun <= 1'b0;
                    end else begin
                        // A second result while unloading is dropped and flagged.
                        if (w_rise) begin
                            r_overrun <= 1'b1;
                        end
                        if (rd_pop && r_valid) begin
                            if (r_idx == c_LAST_IDX) begin
                                r_valid <= 1'b0;
                                r_idx   <= '0;
                                r_state <= BEC_IDLE;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= BEC_IDLE;
                end
            endcase
        end
    end

    bec_word_mux #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .IDX_W  (BEC_IDX_W)
    ) u_word_mux (
        .i_data (r_capture),
        .i_idx  (r_idx),
        .o_word (w_word)
    );

    assign word_out   = r_valid ? w_word : '0;
    assign word_idx   = r_idx;
    assign word_valid = r_valid;
    assign last_word  = r_valid && (r_idx == c_LAST_IDX);
    assign busy       = (r_state != BEC_IDLE);
    assign status_out = r_status;
    assign overrun    = r_overrun;

endmodule : bec_result_reader
`default_nettype wire

// File: tb/tb_bec_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bec_result_reader
// Description : Directed, table-driven self-checking bench for bec_result_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bec_result_reader;

    localparam int DW = 163;

    logic          clk;
    logic          rst_n;
    logic          arm;
    logic          done;
    logic [DW-1:0] data;
    logic [3:0]    st;
    logic          pop;
    logic [31:0]   word_out;
    logic [2:0]    word_idx;
    logic          word_valid;
    logic          last_word;
    logic          busy;
    logic [3:0]    status_out;
    logic          overrun;

    int n_err;
    int n_checks;

    bec_result_reader dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .arm        (arm),
        .slv_done   (done),
        .data_in    (data),
        .bec_status (st),
        .rd_pop     (pop),
        .word_out   (word_out),
        .word_idx   (word_idx),
        .word_valid (word_valid),
        .last_word  (last_word),
        .busy       (busy),
        .status_out (status_out),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          a, d, p;
        logic [DW-1:0] data;
        logic [3:0]    st;
        logic          v;
        logic [2:0]    idx;
        logic [31:0]   w;
        logic          l, b;
        logic [3:0]    so;
        logic          o;
    } vec_t;

    function automatic vec_t mk(logic a, logic d, logic p, logic [DW-1:0] dt, logic [3:0] s,
                                logic v, logic [2:0] idx, logic [31:0] w, logic l, logic b,
                                logic [3:0] so, logic o);
        vec_t r;
        r.a = a; r.d = d; r.p = p; r.data = dt; r.st = s;
        r.v = v; r.idx = idx; r.w = w; r.l = l; r.b = b; r.so = so; r.o = o;
        return r;
    endfunction

    function automatic logic [31:0] exp_word(logic [DW-1:0] d, int k);
        if (k < 5) return d[32*k +: 32];
        return {29'b0, d[162:160]};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic v, logic [2:0] idx, logic [31:0] w, logic l,
                           logic b, logic [3:0] so, logic o);
        chk({tag, ".word_valid"}, 64'(word_valid), 64'(v));
        chk({tag, ".word_idx"},   64'(word_idx),   64'(idx));
        chk({tag, ".word_out"},   64'(word_out),   64'(w));
        chk({tag, ".last_word"},  64'(last_word),  64'(l));
        chk({tag, ".busy"},       64'(busy),       64'(b));
        chk({tag, ".status_out"}, 64'(status_out), 64'(so));
        chk({tag, ".overrun"},    64'(overrun),    64'(o));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t          vecs[21];
    logic [DW-1:0] d1, d2, d3, ones;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_err    = 0;
        n_checks = 0;
        d1   = {3'h5, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D, 32'h12345678};
        d2   = {3'h6, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFEDCBA98, 32'h76543210, 32'hC001D00D};
        d3   = {3'h7, 32'h13579BDF, 32'h2468ACE0, 32'h00000000, 32'hFFFFFFFF, 32'h80000001};
        ones = '1;

        //              a  d  p  data  st     v  idx w             l  b  so    o
        vecs[0]  = mk(0, 1, 0, d1,   4'hA, 0, 0, 32'h0,        0, 0, 4'h0, 0);
        vecs[1]  = mk(0, 0, 1, d1,   4'hA, 0, 0, 32'h0,        0, 0, 4'h0, 0);
        vecs[2]  = mk(1, 0, 0, d1,   4'hA, 0, 0, 32'h0,        0, 1, 4'h0, 0);
        vecs[3]  = mk(0, 0, 1, d1,   4'hA, 0, 0, 32'h0,        0, 1, 4'h0, 0);
        vecs[4]  = mk(0, 1, 0, d1,   4'hA, 1, 0, 32'h12345678, 0, 1, 4'hA, 0);
        vecs[5]  = mk(0, 1, 1, d1,   4'hA, 1, 1, 32'hCAFEF00D, 0, 1, 4'hA, 0);
        vecs[6]  = mk(0, 0, 1, d1,   4'hA, 1, 2, 32'h89ABCDEF, 0, 1, 4'hA, 0);
        vecs[7]  = mk(0, 1, 0, ones, 4'h3, 1, 2, 32'h89ABCDEF, 0, 1, 4'hA, 1);
        vecs[8]  = mk(0, 1, 1, ones, 4'h3, 1, 3, 32'h01234567, 0, 1, 4'hA, 1);
        vecs[9]  = mk(0, 0, 1, ones, 4'h3, 1, 4, 32'hDEADBEEF, 0, 1, 4'hA, 1);
        vecs[10] = mk(0, 0, 1, ones, 4'h3, 1, 5, 32'h00000005, 1, 1, 4'hA, 1);
        vecs[11] = mk(0, 0, 1, ones, 4'h3, 0, 0, 32'h0,        0, 0, 4'hA, 1);
        vecs[12] = mk(1, 1, 0, d2,   4'h5, 0, 0, 32'h0,        0, 1, 4'hA, 0);
        vecs[13] = mk(0, 1, 0, d2,   4'h5, 0, 0, 32'h0,        0, 1, 4'hA, 0);
        vecs[14] = mk(0, 0, 0, d2,   4'h5, 0, 0, 32'h0,        0, 1, 4'hA, 0);
        vecs[15] = mk(0, 1, 0, d2,   4'h5, 1, 0, 32'hC001D00D, 0, 1, 4'h5, 0);
        vecs[16] = mk(0, 1, 1, d2,   4'h5, 1, 1, 32'h76543210, 0, 1, 4'h5, 0);
        vecs[17] = mk(0, 0, 1, d2,   4'h5, 1, 2, 32'hFEDCBA98, 0, 1, 4'h5, 0);
        vecs[18] = mk(0, 0, 1, d2,   4'h5, 1, 3, 32'h0F0F0F0F, 0, 1, 4'h5, 0);
        vecs[19] = mk(1, 0, 1, d2,   4'h5, 0, 0, 32'h0,        0, 1, 4'h5, 0);
        vecs[20] = mk(0, 1, 0, d3,   4'hC, 1, 0, 32'h80000001, 0, 1, 4'hC, 0);

        rst_n = 1'b0;
        arm = 1'b0; done = 1'b0; pop = 1'b0; data = '0; st = '0;
        tick();
        tick();
        chk_all("reset", 0, 0, 32'h0, 0, 0, 4'h0, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 21; i++) begin
            arm  = vecs[i].a;
            done = vecs[i].d;
            pop  = vecs[i].p;
            data = vecs[i].data;
            st   = vecs[i].st;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].w, vecs[i].l,
                    vecs[i].b, vecs[i].so, vecs[i].o);
        end

        // Asynchronous reset between edges while unloading d3.
        arm = 1'b0; done = 1'b0; pop = 1'b1;
        tick();
        tick();
        chk("pre_rst.word_idx", 64'(word_idx), 64'd2);
        pop = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 32'h0, 0, 0, 4'h0, 0);
        #2 rst_n = 1'b1;
        pop = 1'b1;
        tick();
        tick();
        chk_all("post_rst_pop", 0, 0, 32'h0, 0, 0, 4'h0, 0);

        // Back-to-back: full unload of d1, re-arm next cycle, capture d3.
        pop = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0; done = 1'b1; data = d1; st = 4'h9;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b1.w%0d", k), 64'(word_out), 64'(exp_word(d1, k)));
            chk($sformatf("b2b1.idx%0d", k), 64'(word_idx), 64'(k));
            chk($sformatf("b2b1.last%0d", k), 64'(last_word), 64'(k == 5));
            pop = 1'b1;
            tick();
        end
        chk("b2b1.end_valid", 64'(word_valid), 64'd0);
        chk("b2b1.end_busy", 64'(busy), 64'd0);
        pop = 1'b0; arm = 1'b1; done = 1'b0;
        tick();
        chk("b2b2.armed_busy", 64'(busy), 64'd1);
        arm = 1'b0; done = 1'b1; data = d3; st = 4'h6;
        tick();
        chk("b2b2.status", 64'(status_out), 64'h6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("b2b2.w%0d", k), 64'(word_out), 64'(exp_word(d3, k)));
            chk($sformatf("b2b2.valid%0d", k), 64'(word_valid), 64'd1);
            pop = 1'b1;
            tick();
        end
        chk("b2b2.end_valid", 64'(word_valid), 64'd0);
        chk("b2b2.end_overrun", 64'(overrun), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_bec_result_reader
`default_nettype wire
